iterative_muldiv: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that runs beside the ALU in the multicycle datapath and implements the RV32M operations.
- The control FSM issues a one-cycle start with operands from the A/B registers, stalls on busy, and writes result into ALUOut when done pulses.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle, with fast paths for the divide special cases.

---
 rtl/iterative_muldiv.sv | 188 ++++++++++++++++++
 tb/tb_iterative_muldiv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : iterative_muldiv
// Description : RV32M multiply/divide unit. Radix-2 shift-add multiply and
//               restoring divide, one bit per cycle. The divide special cases
//               (b=0 and signed overflow) complete on a fast path. Defining
//               MULDIV_DIV_EN builds the divider; without it, divide opcodes
//               complete immediately with result 0 and illegal set.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int CNT_W = $clog2(XLEN) + 1;
`ifdef MULDIV_DIV_EN
    localparam bit c_DIV_EN = 1'b1;
`else
    localparam bit c_DIV_EN = 1'b0;
`endif
    localparam logic [2:0]      c_OP_MULH   = 3'b001;
    localparam logic [2:0]      c_OP_MULHSU = 3'b010;
    localparam logic [2:0]      c_OP_DIV    = 3'b100;
    localparam logic [2:0]      c_OP_REM    = 3'b110;
    localparam logic [XLEN-1:0] c_MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_op;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic [XLEN-1:0]     r_result;
    logic                r_illegal;

    logic                w_accept;
    logic                w_sgn_a;
    logic                w_sgn_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_res;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_acc;
    logic [2*XLEN-1:0]   w_div_acc;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_mul_res;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;

    assign result  = r_result;
    assign illegal = r_illegal;

    // Operand conditioning: the iterative core works on magnitudes only
    assign w_sgn_a    = (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
                        (op == c_OP_DIV)  || (op == c_OP_REM);
    assign w_sgn_b    = (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);
    assign w_neg_a    = w_sgn_a & a[XLEN-1];
    assign w_neg_b    = w_sgn_b & b[XLEN-1];
    assign w_abs_a    = w_neg_a ? -a : a;
    assign w_abs_b    = w_neg_b ? -b : b;
    assign w_div_zero = (b == '0);
    assign w_div_ovf  = w_sgn_b && op[2] && (a == c_MIN_NEG) && (b == '1);
    assign w_fast     = op[2] & (~c_DIV_EN | w_div_zero | w_div_ovf);

    always_comb begin
        w_fast_res = '0;
        if (c_DIV_EN) begin
            if (w_div_zero)
                w_fast_res = op[1] ? a : '1;
            else
                w_fast_res = op[1] ? '0 : a;
        end
    end

    // Multiply: upper half accumulates, lower half holds the shifting multiplier
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

    generate
        if (c_DIV_EN) begin : g_div
            // Upper half is the partial remainder, lower half dividend-in/quotient-out
            logic [XLEN:0] w_diff;
            assign w_diff    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opnd};
            assign w_div_acc = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                            : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin : g_no_div
            assign w_div_acc = '0;
        end
    endgenerate

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
    assign w_quo      = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem      = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_fix_res  = r_op[2] ? (r_op[1] ? w_rem : w_quo) : w_mul_res;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done        = (r_state == S_DONE);
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(1))
                    w_state_nxt = S_FIX;
            end
            S_FIX: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_op      <= op;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_cnt     <= CNT_W'(XLEN);
            r_opnd    <= op[2] ? w_abs_b : w_abs_a;
            r_acc     <= {{XLEN{1'b0}}, (op[2] ? w_abs_a : w_abs_b)};
            if (w_fast) begin
                r_result  <= w_fast_res;
                r_illegal <= ~c_DIV_EN;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_acc <= r_op[2] ? w_div_acc : w_mul_acc;
        end else if (r_state == S_FIX) begin
            r_result  <= w_fix_res;
            r_illegal <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iterative_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_muldiv
// Description : Self-checking bench for iterative_muldiv (XLEN=32) against an
//               arithmetic reference model; honours MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_muldiv;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iterative_muldiv #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .illegal (illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width products and native division, special cases first
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic ill, output int lat);
        logic [63:0] ex, ey, p;
        logic [31:0] q, rm;
        ill = 1'b0;
        lat = LAT;
        if (!o[2]) begin
            ex = (o == 3'b001 || o == 3'b010) ? {{32{x[31]}}, x} : {32'h0, x};
            ey = (o == 3'b001) ? {{32{y[31]}}, y} : {32'h0, y};
            p  = ex * ey;
            r  = (o == 3'b000) ? p[31:0] : p[63:32];
        end else begin
`ifdef MULDIV_DIV_EN
            if (y == 32'h0) begin
                q = 32'hFFFF_FFFF; rm = x; lat = 1;
            end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = x; rm = 32'h0; lat = 1;
            end else if (!o[0]) begin
                q  = $signed(x) / $signed(y);
                rm = $signed(x) % $signed(y);
            end else begin
                q  = x / y;
                rm = x % y;
            end
            r = o[1] ? rm : q;
`else
            r = 32'h0; ill = 1'b1; lat = 1;
`endif
        end
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res,
                             input logic exp_ill, input int inj);
        int cyc = 1;
        int lat = -1;
        int busy_bad = 0;
        while (cyc <= 64) begin
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (cyc == inj) begin
                start = 1'b1; op = 3'b011; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " illegal"}, illegal, exp_ill);
        check({tag, " busy@done"}, busy, 1'b0);
        check({tag, " busy gaps"}, 64'(busy_bad), 64'd0);
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int inj);
        logic [31:0] er;
        logic        ei;
        int          el;
        model(o, x, y, er, ei, el);
        issue(o, x, y);
        wait_done($sformatf("op%0d a=%h b=%h", o, x, y), el, er, ei, inj);
    endtask

    localparam int N_DIR = 12;
    logic [2:0]  dir_op [N_DIR] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101,
                                    3'b101, 3'b110, 3'b100, 3'b110, 3'b000, 3'b111};
    logic [31:0] dir_a  [N_DIR] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC,
                                    32'hFFFF_FFEC, 32'd20, 32'd5, 32'd5, 32'h8000_0000,
                                    32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] dir_b  [N_DIR] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'd3, 32'd3,
                                    32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hFFFF_FFFF, 32'd0};

    initial begin
        int          ndone;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 32'h0);
        check("reset illegal", illegal, 1'b0);

        // MUL with a second start during busy that must be ignored
        run(3'b000, 32'd7, 32'd6, 10);
        @(posedge clk); #1;
        check("done single pulse", done, 1'b0);
        check("mul hold 1", result, 32'h2A);
        repeat (5) @(posedge clk);
        #1;
        check("mul hold 2", result, 32'h2A);
        check("idle busy", busy, 1'b0);

        // Directed cases, issued back-to-back in each DONE cycle
        for (int i = 0; i < N_DIR; i++)
            run(dir_op[i], dir_a[i], dir_b[i], 0);

        // Reset during a long operation
        @(posedge clk); #1;
        run(3'b000, 32'd7, 32'd6, 0);
`ifdef MULDIV_DIV_EN
        issue(3'b100, 32'd1000, 32'd7);
`else
        issue(3'b011, 32'd1000, 32'd7);
`endif
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort result", result, 32'h0);
        check("abort illegal", illegal, 1'b0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("abort no done", 64'(ndone), 64'd0);

        // Randomised operations with occasional idle gaps and special operands
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'h0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: ry = $urandom_range(1, 15);
                3: rx = $urandom_range(0, 255);
                default: ;
            endcase
            run(ro, rx, ry, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
